// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures combinational ROM data into a small
// queue, hands {pc, instr} to decode over valid/ready and traps misaligned redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_rom_addr,
    input  logic [31:0] i_rom_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    input  logic        i_if_ready,
    output logic        o_fault,
    output logic [31:0] o_fault_pc
);

    localparam int               PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  w_wr_ptr_next;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  w_rd_ptr_next;
    logic [31:0]       r_fault_pc;
    logic [31:0]       r_q_pc    [QUEUE_DEPTH];
    logic [31:0]       r_q_instr [QUEUE_DEPTH];

    logic              w_valid;
    logic              w_enq;
    logic              w_deq;
    logic              w_flush;
    logic              w_fault_load;

    assign w_valid = (r_count != '0) && (r_state == ST_RUN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fault_pc <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_count  <= w_count_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            if (w_fault_load) begin
                r_fault_pc <= i_redirect_pc;
            end
        end
    end

    // Redirect beats enqueue; a full queue may still take a new word when the head leaves.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_flush      = 1'b0;
        w_enq        = 1'b0;
        w_deq        = 1'b0;
        w_fault_load = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_redirect_valid) begin
                    w_flush = 1'b1;
                    if (i_redirect_pc[1:0] == 2'b00) begin
                        w_pc_next = i_redirect_pc;
                    end else begin
                        w_state_next = ST_FAULT;
                        w_fault_load = 1'b1;
                    end
                end else begin
                    w_deq = w_valid && i_if_ready;
                    w_enq = (r_count < DEPTH_CNT) || w_deq;
                    if (w_enq) begin
                        w_pc_next = r_pc + 32'd4;
                    end
                end
            end
            ST_FAULT: begin
                w_flush = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_comb begin
        w_count_next  = r_count;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (w_flush) begin
            w_count_next  = '0;
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
        end else begin
            if (w_enq) begin
                w_wr_ptr_next = r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                w_rd_ptr_next = r_rd_ptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                w_count_next = r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                w_count_next = r_count - 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; only count and pointers qualify it.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_q_pc[r_wr_ptr]    <= r_pc;
            r_q_instr[r_wr_ptr] <= i_rom_data;
        end
    end

    assign o_rom_addr = r_pc;
    assign o_if_valid = w_valid;
    assign o_if_instr = w_valid ? r_q_instr[r_rd_ptr] : '0;
    assign o_if_pc    = w_valid ? r_q_pc[r_rd_ptr] : '0;
    assign o_fault    = (r_state == ST_FAULT);
    assign o_fault_pc = r_fault_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a random redirect/ready
// stream compared every cycle against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_A = 32'h0000_0000;
    localparam logic [31:0] RESET_B = 32'hFFFF_FFF8;
    localparam int          DEPTH   = 2;

    logic        clk = 1'b0;
    logic        rstA = 1'b1, rvA = 1'b0, rdyA = 1'b0;
    logic [31:0] rpcA = '0;
    logic [31:0] romAddrA, romDataA, instrA, pcA, faultPcA;
    logic        validA, faultA;

    logic        rstB = 1'b1, rvB = 1'b0, rdyB = 1'b1;
    logic [31:0] rpcB = '0;
    logic [31:0] romAddrB, romDataB, instrB, pcB, faultPcB;
    logic        validB, faultB;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] mPc;
    logic        mFault;
    logic [31:0] mFaultPc;
    logic [31:0] qPc[$];
    logic [31:0] qInstr[$];

    always #5 clk = ~clk;

    // ROM image: two fixed words at the bottom, a pattern in two windows, zero elsewhere.
    function automatic logic [31:0] romWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        if (a < 32'h400 || a >= 32'hFFFF_FF00) return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
        return 32'h0;
    endfunction

    assign romDataA = romWord(romAddrA);
    assign romDataB = romWord(romAddrB);

    fetch_unit #(.RESET_PC(RESET_A), .QUEUE_DEPTH(DEPTH)) dutA (
        .i_clk(clk), .i_rst(rstA), .o_rom_addr(romAddrA), .i_rom_data(romDataA),
        .i_redirect_valid(rvA), .i_redirect_pc(rpcA), .o_if_valid(validA),
        .o_if_instr(instrA), .o_if_pc(pcA), .i_if_ready(rdyA),
        .o_fault(faultA), .o_fault_pc(faultPcA)
    );

    fetch_unit #(.RESET_PC(RESET_B), .QUEUE_DEPTH(DEPTH)) dutB (
        .i_clk(clk), .i_rst(rstB), .o_rom_addr(romAddrB), .i_rom_data(romDataB),
        .i_redirect_valid(rvB), .i_redirect_pc(rpcB), .o_if_valid(validB),
        .o_if_instr(instrB), .o_if_pc(pcB), .i_if_ready(rdyB),
        .o_fault(faultB), .o_fault_pc(faultPcB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPc      = RESET_A;
        mFault   = 1'b0;
        mFaultPc = '0;
        qPc.delete();
        qInstr.delete();
    endtask

    // One clock edge of the fetch stage, described as queue operations.
    task automatic modelStep(input logic rst, input logic rv, input logic [31:0] rpc,
                             input logic rdy);
        logic [31:0] dropped;
        if (rst) begin
            modelReset();
        end else if (!mFault) begin
            if (rv) begin
                qPc.delete();
                qInstr.delete();
                if (rpc % 4 == 0) begin
                    mPc = rpc;
                end else begin
                    mFault   = 1'b1;
                    mFaultPc = rpc;
                end
            end else begin
                if (qPc.size() > 0 && rdy) begin
                    dropped = qPc.pop_front();
                    dropped = qInstr.pop_front();
                end
                if (qPc.size() < DEPTH) begin
                    qPc.push_back(mPc);
                    qInstr.push_back(romWord(mPc));
                    mPc = mPc + 32'd4;
                end
            end
        end
    endtask

    task automatic compareModel();
        checkOutput("rom_addr", romAddrA, mPc);
        checkOutput("if_valid", {31'b0, validA}, {31'b0, qPc.size() != 0});
        checkOutput("fault", {31'b0, faultA}, {31'b0, mFault});
        checkOutput("fault_pc", faultPcA, mFaultPc);
        if (qPc.size() != 0) begin
            checkOutput("if_pc", pcA, qPc[0]);
            checkOutput("if_instr", instrA, qInstr[0]);
        end
    endtask

    // Checks the current state at the falling edge, then drives one cycle of inputs.
    task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                                 input logic rdy);
        @(negedge clk);
        compareModel();
        rstA = rst;
        rvA  = rv;
        rpcA = rpc;
        rdyA = rdy;
        modelStep(rst, rv, rpc, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        r, v, d;
        logic [31:0] t;

        repeat (2) @(posedge clk);
        modelReset();
        @(negedge clk);
        checkOutput("rst_if_valid", {31'b0, validA}, 32'd0);
        checkOutput("rst_if_instr", instrA, 32'd0);
        checkOutput("rst_if_pc", pcA, 32'd0);
        checkOutput("rst_fault", {31'b0, faultA}, 32'd0);
        checkOutput("rst_rom_addr", romAddrA, RESET_A);

        $display("[TB] straight-line fetch");
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("t1_pc0", pcA, 32'h0);
        checkOutput("t1_instr0", instrA, 32'h0000_0013);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("t1_pc4", pcA, 32'h4);
        checkOutput("t1_instr4", instrA, 32'h0010_0093);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("t1_pc8", pcA, 32'h8);

        $display("[TB] stall then drain");
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("t2_rom_addr_stuck", romAddrA, 32'(4 * DEPTH));
        checkOutput("t2_head_pc", pcA, 32'h0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("t2_drain_pc4", pcA, 32'h4);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("t2_drain_pc8", pcA, 32'h8);
        repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1);

        $display("[TB] redirect from full queue");
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
        checkOutput("t3_flush_valid", {31'b0, validA}, 32'd0);
        checkOutput("t3_rom_addr", romAddrA, 32'h100);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("t3_target_pc", pcA, 32'h100);

        $display("[TB] misaligned redirect");
        applyStimulus(1'b0, 1'b1, 32'h102, 1'b1);
        checkOutput("t4_fault", {31'b0, faultA}, 32'd1);
        checkOutput("t4_fault_pc", faultPcA, 32'h102);
        checkOutput("t4_valid", {31'b0, validA}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1);
        checkOutput("t4_ignored_redirect", romAddrA, 32'h104);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("t4_rst_fault", {31'b0, faultA}, 32'd0);
        checkOutput("t4_rst_rom_addr", romAddrA, RESET_A);

        $display("[TB] random stream");
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       t = 32'h8000 + 32'($urandom_range(0, 15)) * 4;
                1:       t = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
                2:       t = 32'hFFFF_FFF0;
                default: t = 32'($urandom_range(0, 255)) * 4;
            endcase
            applyStimulus(r, v, t, d);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        $display("[TB] PC wrap from top of memory");
        @(negedge clk);
        rstB = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_rst_rom_addr", romAddrB, RESET_B);
        checkOutput("t5_rst_valid", {31'b0, validB}, 32'd0);
        @(negedge clk);
        rstB = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_pc_fff8", pcB, 32'hFFFF_FFF8);
        checkOutput("t5_instr_fff8", instrB, romWord(32'hFFFF_FFF8));
        @(posedge clk);
        #1;
        checkOutput("t5_pc_fffc", pcB, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        checkOutput("t5_pc_wrap", pcB, 32'h0000_0000);
        checkOutput("t5_instr_wrap", instrB, 32'h0000_0013);
        checkOutput("t5_rom_addr_wrap", romAddrB, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
